// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the two-port ALU arbiter.
// slave = arbiter view; master = requesters plus ALU view.
interface alu_arbiter_if #(
   parameter int WORDSIZE = 64
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [WORDSIZE-1:0] req_a0;
   logic [WORDSIZE-1:0] req_a1;
   logic [WORDSIZE-1:0] req_b0;
   logic [WORDSIZE-1:0] req_b1;
   logic [5:0]          req_op0;
   logic [5:0]          req_op1;
   logic [1:0]          resp_valid;
   logic [1:0]          resp_ready;
   logic [WORDSIZE-1:0] resp_result;
   logic [7:0]          resp_flags;
   logic [WORDSIZE-1:0] alu_input_a;
   logic [WORDSIZE-1:0] alu_input_b;
   logic [5:0]          alu_operation;
   logic [WORDSIZE-1:0] alu_result;
   logic [7:0]          alu_flags;

   modport slave (
      input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
      output req_ready,
      output resp_valid, resp_result, resp_flags,
      input  resp_ready,
      output alu_input_a, alu_input_b, alu_operation,
      input  alu_result, alu_flags
   );

   modport master (
      output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
      input  req_ready,
      input  resp_valid, resp_result, resp_flags,
      output resp_ready,
      input  alu_input_a, alu_input_b, alu_operation,
      output alu_result, alu_flags
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two ports; response valid 2 cycles after accept.
// One transaction in flight; req_ready drops until the owner consumes the held response.
module alu_arbiter #(
   parameter int WORDSIZE = 64
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   typedef struct packed {
      logic [WORDSIZE-1:0] a;
      logic [WORDSIZE-1:0] b;
      logic [5:0]          op;
   } req_t;

   state_t              state;
   state_t              state_nxt;
   logic                owner;
   logic                last_grant;
   logic                grant;
   logic                accept;
   logic [1:0]          req_ready_c;
   logic [1:0]          resp_valid_c;
   req_t                req_sel;
   req_t                alu_req;
   logic [WORDSIZE-1:0] resp_result;
   logic [7:0]          resp_flags;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // On contention the port that did not win last time gets the grant.
   always_comb begin
      state_nxt    = state;
      grant        = 1'b0;
      accept       = 1'b0;
      req_ready_c  = 2'b00;
      resp_valid_c = 2'b00;
      case (state)
         IDLE: begin
            grant = bus.req_valid[1] && (!bus.req_valid[0] || !last_grant);
            if (!reset && (bus.req_valid != 2'b00)) begin
               accept      = 1'b1;
               req_ready_c = grant ? 2'b10 : 2'b01;
               state_nxt   = ISSUE;
            end
         end
         ISSUE: state_nxt = RESP;
         RESP: begin
            resp_valid_c = owner ? 2'b10 : 2'b01;
            if (bus.resp_ready[owner]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if (grant) req_sel = '{a: bus.req_a1, b: bus.req_b1, op: bus.req_op1};
      else       req_sel = '{a: bus.req_a0, b: bus.req_b0, op: bus.req_op0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_req     <= '0;
         owner       <= 1'b0;
         last_grant  <= 1'b1;
         resp_result <= '0;
         resp_flags  <= '0;
      end else begin
         if (accept) begin
            alu_req    <= req_sel;
            owner      <= grant;
            last_grant <= grant;
         end
         if (state == ISSUE) begin
            resp_result <= bus.alu_result;
            resp_flags  <= bus.alu_flags;
         end
      end
   end

   assign bus.req_ready     = req_ready_c;
   assign bus.resp_valid    = resp_valid_c;
   assign bus.resp_result   = resp_result;
   assign bus.resp_flags    = resp_flags;
   assign bus.alu_input_a   = alu_req.a;
   assign bus.alu_input_b   = alu_req.b;
   assign bus.alu_operation = alu_req.op;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed scenarios, then randomized traffic
// checked against a transaction-level model of grant order, timing and data routing.
module tb_alu_arbiter;
   localparam int W = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WORDSIZE(W)) bus ();
   alu_arbiter #(.WORDSIZE(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Behavioural ALU: op 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass a.
   function automatic logic [W+7:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [5:0] op);
      logic [W-1:0] r;
      logic         ov;
      ov = 1'b0;
      case (op)
         6'd0: begin r = a + b; ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
         6'd1: begin r = a - b; ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
         6'd2: r = a & b;
         6'd3: r = a | b;
         6'd4: r = a ^ b;
         default: r = a;
      endcase
      return {r, ov, a == b, a != b, $signed(a) > $signed(b), $signed(a) < $signed(b),
              a == b, a > b, a < b};
   endfunction

   always_comb {bus.alu_result, bus.alu_flags} = alu_ref(bus.alu_input_a, bus.alu_input_b,
                                                         bus.alu_operation);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Stimulus for the next cycle
   logic         d_rst;
   logic [1:0]   d_vld;
   logic [1:0]   d_rrdy;
   logic [W-1:0] d_a [2];
   logic [W-1:0] d_b [2];
   logic [5:0]   d_op [2];
   logic         chk_en;

   // Transaction-level model
   bit           in_flight;
   int           age;
   logic         m_owner;
   logic         m_last;
   logic [W-1:0] m_a, m_b, m_res;
   logic [5:0]   m_op;
   logic [7:0]   m_flg;
   int           cyc;
   int           acc_q[$];

   task automatic model_reset();
      in_flight = 0; age = 0; m_owner = 1'b0; m_last = 1'b1;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = '0;
   endtask

   task automatic set_req(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [5:0] op);
      d_a[p] = a; d_b[p] = b; d_op[p] = op;
   endtask

   task automatic step();
      logic [1:0] exp_rdy, exp_rv;
      logic       g;
      @(negedge clk);
      reset          = d_rst;
      bus.req_valid  = d_vld;
      bus.resp_ready = d_rrdy;
      bus.req_a0 = d_a[0]; bus.req_b0 = d_b[0]; bus.req_op0 = d_op[0];
      bus.req_a1 = d_a[1]; bus.req_b1 = d_b[1]; bus.req_op1 = d_op[1];
      #1;
      exp_rdy = 2'b00;
      g = 1'b0;
      if (!in_flight && !d_rst && d_vld != 2'b00) begin
         g = (d_vld == 2'b11) ? !m_last : d_vld[1];
         exp_rdy = g ? 2'b10 : 2'b01;
      end
      exp_rv = (in_flight && age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      if (chk_en) begin
         check("req_ready", bus.req_ready, exp_rdy);
         check("resp_valid", bus.resp_valid, exp_rv);
         check("resp_result", bus.resp_result, m_res);
         check("resp_flags", bus.resp_flags, m_flg);
         check("alu_input_a", bus.alu_input_a, m_a);
         check("alu_input_b", bus.alu_input_b, m_b);
         check("alu_operation", bus.alu_operation, m_op);
      end
      if (bus.req_ready[0] && d_vld[0]) acc_q.push_back(cyc);
      if (d_rst) model_reset();
      else if (in_flight) begin
         if (age == 1) {m_res, m_flg} = alu_ref(m_a, m_b, m_op);
         if (age >= 2 && d_rrdy[m_owner]) in_flight = 0;
         age++;
      end else if (exp_rdy != 2'b00) begin
         in_flight = 1; age = 1; m_owner = g; m_last = g;
         m_a = d_a[g]; m_b = d_b[g]; m_op = d_op[g];
      end
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      d_vld = 2'b00; d_rrdy = 2'b11; d_rst = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   bit hold[2];

   initial begin
      cyc = 0; chk_en = 0;
      d_rst = 1'b1; d_vld = 2'b00; d_rrdy = 2'b00;
      for (int p = 0; p < 2; p++) set_req(p, '0, '0, '0);
      model_reset();
      step(); step();
      chk_en = 1;
      d_rst = 1'b0;
      step();                                       // reset state

      // Port 0 alone: 5 + 3
      set_req(0, 64'd5, 64'd3, 6'd0); d_vld = 2'b01; d_rrdy = 2'b11;
      step(); check("t1_ready", bus.req_ready, 2'b01);
      d_vld = 2'b00;
      step(); check("t1_no_resp_issue", bus.resp_valid, 2'b00);
      step(); check("t1_resp_valid", bus.resp_valid, 2'b01);
      check("t1_result", bus.resp_result, 64'd8);
      check("t1_flags", bus.resp_flags, 8'b0011_0010);
      idle_steps(1);

      // Contention from reset: p0 first, then p1, then p0 again
      d_rst = 1'b1; step(); d_rst = 1'b0;
      set_req(0, 64'd10, 64'd4, 6'd1); set_req(1, 64'hF0, 64'h3C, 6'd2);
      d_vld = 2'b11; d_rrdy = 2'b11;
      step(); check("t2_first_grant", bus.req_ready, 2'b01);
      step(); step(); check("t2_p0_result", bus.resp_result, 64'd6);
      check("t2_p0_valid", bus.resp_valid, 2'b01);
      step(); check("t2_second_grant", bus.req_ready, 2'b10);
      step(); step(); check("t2_p1_result", bus.resp_result, 64'h30);
      step(); check("t2_third_grant", bus.req_ready, 2'b01);
      idle_steps(4);

      // Backpressure on port 1 for 5 cycles; port 0 waits, non-owner ready ignored
      set_req(1, 64'd77, 64'd11, 6'd3); d_vld = 2'b10; d_rrdy = 2'b11;
      step(); check("t3_grant", bus.req_ready, 2'b10);
      d_vld = 2'b00; d_rrdy = 2'b01;
      step();
      set_req(0, 64'd1, 64'd2, 6'd4); d_vld = 2'b01;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold_valid", bus.resp_valid, 2'b10);
         check("t3_hold_result", bus.resp_result, 64'd77 | 64'd11);
         check("t3_no_ready", bus.req_ready, 2'b00);
      end
      d_rrdy = 2'b11; step();
      step(); check("t3_idle_after", bus.req_ready, 2'b01);
      idle_steps(3);

      // Reset while in ISSUE drops the transaction
      set_req(0, 64'd9, 64'd9, 6'd0); d_vld = 2'b01;
      step();
      d_vld = 2'b00; d_rst = 1'b1; step(); d_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t4_no_resp", bus.resp_valid, 2'b00);
         check("t4_result_zero", bus.resp_result, '0);
         check("t4_alu_a_zero", bus.alu_input_a, '0);
      end
      d_vld = 2'b11; step(); check("t4_tie_port0", bus.req_ready, 2'b01);
      idle_steps(4);

      // Back-to-back on port 0
      acc_q.delete();
      set_req(0, 64'd100, 64'd1, 6'd1); d_vld = 2'b01; d_rrdy = 2'b11;
      for (int i = 0; i < 10; i++) step();
      idle_steps(3);
      check("t5_accepts", acc_q.size(), 4);
      for (int i = 1; i < acc_q.size(); i++) check("t5_interval", acc_q[i] - acc_q[i-1], 3);

      // Signed overflow on port 1
      set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0); d_vld = 2'b10;
      step(); d_vld = 2'b00; step(); step();
      check("t6_valid_p1_only", bus.resp_valid, 2'b10);
      check("t6_overflow", bus.resp_flags[7], 1'b1);
      check("t6_result", bus.resp_result, 64'h8000_0000_0000_0000);
      idle_steps(2);

      // Randomized traffic, honouring the hold-while-waiting rule
      hold[0] = 0; hold[1] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!hold[p]) begin
               d_vld[p] = ($urandom_range(0, 2) != 0);
               set_req(p, {$urandom, $urandom}, {$urandom, $urandom}, 6'($urandom_range(0, 7)));
               if ($urandom_range(0, 3) == 0) d_b[p] = d_a[p];
            end
         end
         d_rrdy = 2'($urandom);
         d_rst  = ($urandom_range(0, 199) == 0);
         step();
         for (int p = 0; p < 2; p++) hold[p] = d_vld[p] && !bus.req_ready[p];
      end
      idle_steps(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
